// File: rtl/lpc_div_pkg.sv
// Shared definitions for the pipelined LPC restoring divider.
// Build option: define LPC_DIV_SIGNED_EN to enable signed (two's-complement) operation.
package lpc_div_pkg;

  // Upper bound on operand width; also sizes the divide-by-zero quotient constant.
  localparam int unsigned MAX_WIDTH = 256;

  // Quotient reported on divide-by-zero, sliced to the operand width by the user.
  localparam logic [MAX_WIDTH-1:0] Q_DIV_ZERO = '1;

  // Legal configuration: WIDTH >= 4, bounded, and an exact multiple of BITS_PER_STAGE.
  function automatic bit params_ok(input int unsigned width, input int unsigned bps);
    return (width >= 4) && (width <= MAX_WIDTH) && (bps != 0) && ((width % bps) == 0);
  endfunction

  // Packed width of one stage payload:
  // {valid, A[W], B[W], R[W+1], Q[W], sign_q, sign_r, div_zero, tag[TAG_W]}.
  // Every stage_t typedef in the divider must keep exactly this field order.
  function automatic int unsigned stage_bits(input int unsigned width, input int unsigned tag_w);
    return 4 * width + 5 + tag_w;
  endfunction

endpackage

// File: rtl/lpc_div_step.sv
// One iterate stage of the pipelined restoring divider: BITS_PER_STAGE
// shift/compare/subtract steps followed by an enable-gated stage register.
// Build option: none (sign handling lives in the top level, under LPC_DIV_SIGNED_EN).
module lpc_div_step
  import lpc_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_W          = 5,
  localparam int unsigned STAGE_W       = stage_bits(WIDTH, TAG_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [STAGE_W-1:0] stage_i,
  output logic [STAGE_W-1:0] stage_o
);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH:0]    r;
    logic [WIDTH-1:0]  q;
    logic              sign_q;
    logic              sign_r;
    logic              div_zero;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  stage_t           cur;
  stage_t           stage_d;
  stage_t           stage_q;
  logic [WIDTH:0]   r_v;
  logic [WIDTH-1:0] a_v;
  logic [WIDTH-1:0] q_v;

  assign cur     = stage_i;
  assign stage_o = stage_q;

  // Restoring steps: shift {R, A} left, subtract B when R >= B, shift the result bit into Q.
  always_comb begin
    r_v = cur.r;
    a_v = cur.a;
    q_v = cur.q;
    for (int unsigned k = 0; k < BITS_PER_STAGE; k++) begin
      r_v = {r_v[WIDTH-1:0], a_v[WIDTH-1]};
      a_v = {a_v[WIDTH-2:0], 1'b0};
      if (r_v >= {1'b0, cur.b}) begin
        r_v = r_v - {1'b0, cur.b};
        q_v = {q_v[WIDTH-2:0], 1'b1};
      end else begin
        q_v = {q_v[WIDTH-2:0], 1'b0};
      end
    end
    stage_d   = cur;
    stage_d.r = r_v;
    stage_d.a = a_v;
    stage_d.q = q_v;
  end

  // Stage register: holds (bubbles included) whenever the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/lpc_pipe_divider.sv
// Fully pipelined restoring divider for the LPC reflection-coefficient path:
// prepare stage, WIDTH/BITS_PER_STAGE iterate stages, finish stage, with a
// single global advance enable for valid/ready backpressure.
// Build option: LPC_DIV_SIGNED_EN enables in_signed and the sign-magnitude logic.
module lpc_pipe_divider
  import lpc_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_zero
);

  localparam int unsigned N       = WIDTH / BITS_PER_STAGE;
  localparam int unsigned STAGE_W = stage_bits(WIDTH, TAG_W);

  if (!params_ok(WIDTH, BITS_PER_STAGE)) begin : g_bad_params
    $fatal(1, "lpc_pipe_divider: WIDTH must be >= 4 and a multiple of BITS_PER_STAGE");
  end

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH:0]    r;
    logic [WIDTH-1:0]  q;
    logic              sign_q;
    logic              sign_r;
    logic              div_zero;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  logic               en;
  stage_t             prep_d;
  stage_t             prep_q;
  logic [STAGE_W-1:0] stg [0:N];
  stage_t             last;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;
  logic               out_valid_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [TAG_W-1:0]   tag_q;
  logic               dz_q;
  logic               unused_fin;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Prepare: operand magnitudes, result signs and the divide-by-zero flag.
  always_comb begin
    prep_d          = '0;
    prep_d.valid    = in_valid;
    prep_d.a        = in_dividend;
    prep_d.b        = in_divisor;
    prep_d.div_zero = (in_divisor == '0);
    prep_d.tag      = in_tag;
`ifdef LPC_DIV_SIGNED_EN
    if (in_signed) begin
      if (in_dividend[WIDTH-1]) prep_d.a = -in_dividend;
      if (in_divisor[WIDTH-1])  prep_d.b = -in_divisor;
      prep_d.sign_q = in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
      prep_d.sign_r = in_dividend[WIDTH-1];
    end
`endif
  end

  // Prepare stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prep_q <= '0;
    end else if (en) begin
      prep_q <= prep_d;
    end
  end

  assign stg[0] = prep_q;

  for (genvar i = 0; i < N; i++) begin : g_step
    lpc_div_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE),
      .TAG_W          (TAG_W)
    ) u_step (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .stage_i (stg[i]),
      .stage_o (stg[i+1])
    );
  end

  assign last = stg[N];

  // Dividend and divisor are fully consumed by the last iterate stage; R's top bit is always 0 there.
  assign unused_fin = ^{last.a, last.b, last.r[WIDTH], last.sign_q, last.sign_r, in_signed};

  // Finish: restore signs (truncating division); divide-by-zero forces an all-ones quotient.
  // The remainder needs no override: with B = 0 it ends up as the dividend magnitude,
  // and sign restoration turns that back into the original dividend.
  always_comb begin
    quot_d = last.q;
    rem_d  = last.r[WIDTH-1:0];
`ifdef LPC_DIV_SIGNED_EN
    if (last.sign_q) quot_d = -last.q;
    if (last.sign_r) rem_d  = -last.r[WIDTH-1:0];
`endif
    if (last.div_zero) quot_d = Q_DIV_ZERO[WIDTH-1:0];
  end

  // Finish/output register: holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      dz_q        <= 1'b0;
    end else if (en) begin
      out_valid_q <= last.valid;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      tag_q       <= last.tag;
      dz_q        <= last.div_zero;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_tag       = tag_q;
  assign out_div_zero  = dz_q;

endmodule
